// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scanner
// Description : Time-multiplexed driver for a four-digit common-anode
//               7-segment display. A 16-bit hex value plus decimal points is
//               captured into a pending register on load and handed to the
//               display register only at frame boundaries, so a digit never
//               tears mid-frame. Each digit slot opens with a ghost-blanking
//               gap (all anodes off) so segments never bleed between digits.
// Ports       : clk        - system clock
//               reset      - synchronous, active-high reset
//               value      - four hex nibbles, value[3:0] drives an[0]
//               load       - one-cycle strobe capturing value/dp_in
//               dp_in      - decimal-point enables per digit, active-high
//               blank      - per-digit force-blank mask (live)
//               lz_en      - leading-zero blanking enable (live)
//               seg        - {g,f,e,d,c,b,a}, active-low
//               dp         - decimal point, active-low
//               an         - anodes, active-low, at most one low
//               frame_done - one-cycle pulse after digit 3's slot ends
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST_CYC   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int              c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_TC    = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GHOST = c_CNT_W'(GHOST_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // Encoding equals the digit index, so the state doubles as the digit select.
    localparam logic [1:0] c_D0 = 2'd0;
    localparam logic [1:0] c_D1 = 2'd1;
    localparam logic [1:0] c_D2 = 2'd2;
    localparam logic [1:0] c_D3 = 2'd3;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [15:0]        r_pend_val;
    logic [3:0]         r_pend_dp;
    logic               r_pend_v;
    logic [15:0]        r_disp_val;
    logic [3:0]         r_disp_dp;

    logic               w_tc;
    logic               w_fb;
    logic [1:0]         w_dig;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic [3:0]         w_lz;
    logic               w_blank_cur;
    logic [3:0]         w_an_nxt;
    logic [6:0]         w_seg_nxt;
    logic               w_dp_nxt;

    assign w_tc  = (r_cnt == c_TC);
    assign w_fb  = w_tc && (r_state == c_D3);
    assign w_dig = r_state;

    // ------------------------------------------------------------------
    // Slot prescaler
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Digit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_D0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Digit FSM: next state, advancing only on terminal count
    always_comb begin
        w_state_nxt = r_state;
        if (w_tc) begin
            case (r_state)
                c_D0:    w_state_nxt = c_D1;
                c_D1:    w_state_nxt = c_D2;
                c_D2:    w_state_nxt = c_D3;
                c_D3:    w_state_nxt = c_D0;
                default: w_state_nxt = c_D0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending and display registers. A load coinciding with the frame
    // boundary bypasses the pending register and wins over older data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_v   <= 1'b0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
        end else if (w_fb) begin
            r_pend_v <= 1'b0;
            if (load) begin
                r_disp_val <= value;
                r_disp_dp  <= dp_in;
            end else if (r_pend_v) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
        end else if (load) begin
            r_pend_val <= value;
            r_pend_dp  <= dp_in;
            r_pend_v   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection: digit d is suppressed when it and every
    // higher nibble are zero. Digit 0 always shows.
    // ------------------------------------------------------------------
    generate
        for (genvar d = 0; d < 4; d++) begin : g_lz
            if (d == 0) begin : g_lz_dig0
                assign w_lz[d] = 1'b0;
            end else begin : g_lz_dign
                assign w_lz[d] = lz_en && (r_disp_val[15:4*d] == '0);
            end
        end
    endgenerate

    assign w_nib       = r_disp_val[{w_dig, 2'b00} +: 4];
    assign w_blank_cur = blank[w_dig] | w_lz[w_dig];

    // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_nib)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit FSM: output decode. A blanked digit keeps its anode driven so
    // the scan duty cycle stays uniform across digits.
    // ------------------------------------------------------------------
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = 7'b1111111;
        w_dp_nxt  = 1'b1;
        if (r_cnt >= c_GHOST) begin
            w_an_nxt[w_dig] = 1'b0;
            if (!w_blank_cur) begin
                w_seg_nxt = w_seg_dec;
                w_dp_nxt  = ~r_disp_dp[w_dig];
            end
        end
    end

    // Registered outputs: one cycle of latency from counter/FSM state
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= w_an_nxt;
            seg        <= w_seg_nxt;
            dp         <= w_dp_nxt;
            frame_done <= w_fb;
        end
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the Basys3 four-digit common-anode 7-segment display. It is the output-side counterpart to the button debouncer: the debouncer conditions user input, and this block presents results back to the user. It latches a 16-bit hex value, transfers it to the display only on frame boundaries so digits never tear, and cycles the four anodes. A short ghost-blanking gap precedes each digit so segments never bleed between digits.

## Interface
- REFRESH_DIV, 100000 — clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 4..2^20.
- GHOST_CYC, 500 — cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- value  in  16  four hex nibbles; value[3:0] is the rightmost digit (an[0]).
- load  in  1  one-cycle strobe; captures value and dp_in into the pending register.
- dp_in  in  4  decimal-point enables per digit, active-high.
- blank  in  4  per-digit force-blank mask, active-high; sampled live, not latched.
- lz_en  in  1  leading-zero blanking enable; sampled live.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anodes, active-low, at most one low at any time.
- frame_done  out  1  one-cycle pulse when digit 3's slot ends.

## Operation
- Prescaler: `cnt` counts 0..REFRESH_DIV-1 and wraps to 0. The terminal count (tc) occurs at `cnt == REFRESH_DIV-1`.
- Digit FSM: states D0→D1→D2→D3→D0, advancing on tc only.
- Pending register: `load` writes {value, dp_in} and sets `pend_v`. A later load before the boundary overwrites it (last wins).
- Frame boundary is tc while in D3:
  - If `load` is asserted in that same cycle, the display register takes the new value and dp_in directly (bypass).
  - Otherwise, if `pend_v` is set, the display register takes the pending contents.
  - `pend_v` clears in either case. With no new data, the display register holds.
- Digit blanking applies to digit d when any of the following holds:
  - blank[d] is set.
  - lz_en is set, d > 0, and nibble d plus every higher nibble of the display register is 0.
  - Digit 0 is never lz-blanked.
- Outputs for the current digit d:
  - During ghost (`cnt < GHOST_CYC`): an=1111, seg=1111111, dp=1.
  - Otherwise, if d is blanked: an[d]=0 (anode still driven), seg=1111111, dp=1.
  - Otherwise: an[d]=0, seg=decode(nibble d), dp=~dp_reg[d].
- Decode table (0..F): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.

## Timing
- seg, dp, an and frame_done are registered with one cycle of latency: outputs in cycle n+1 reflect `cnt`/FSM/display state in cycle n.
- Reset, synchronous and dominant over load:
  - cnt=0, FSM=D0, display register=0, dp_reg=0, pend_v=0.
  - an=1111, seg=1111111, dp=1, frame_done=0.
- After reset is released, the first ghost window lasts GHOST_CYC cycles. an becomes 1110 in cycle GHOST_CYC+1, counting the first cycle with reset low as cycle 1.
- Digit period is exactly REFRESH_DIV cycles. Frame period is exactly 4·REFRESH_DIV cycles.
- frame_done is high for exactly one cycle, the cycle after the D3 tc.
- Display update latency is anywhere from 1 to 4·REFRESH_DIV cycles after load. The new value first appears on digit 0 of the next frame.
- Reset asserted mid-frame aborts the frame. Pending data is discarded and no frame_done is generated.
- blank and lz_en changes take effect in the cycle after they change, with no wait for the frame boundary.

## Test plan
All scenarios use REFRESH_DIV=8 and GHOST_CYC=2.
- Reset release, no load: an sequence 1111×2, 1110×6, 1111×2, 1101×6, and so on. seg=1000000 on every driven digit, dp=1, and frame_done pulses every 32 cycles.
- Load value=16'h1A3F and dp_in=4'b0100 mid-D1: digits unchanged until the frame boundary. Next frame: D0 seg=0001110, D1 0110000, D2 0001000 with dp=0, D3 1111001.
- Two loads in one frame (16'h1111, then 16'h2222) followed by a load exactly at the D3 tc with 16'h3333: the next frame displays 3333 (the bypass wins).
- lz_en=1 with value 16'h0050: D3 and D2 have an low but seg=1111111. D1=0010010 and D0=1000000. With value 16'h0000, only D0 shows 1000000.
- blank=4'b0001 with value 16'h1234: D0 shows seg=1111111 and dp=1 while its anode is low, and the other digits decode normally. Clearing blank restores D0 to 0011001 in the next cycle.
- Reset asserted for 1 cycle mid-D2 with pending data: outputs return to 1111/1111111 in the next cycle. No frame_done fires, and the pending value never appears (the display shows 0000).
